// File: rtl/laser_pkg.sv
// Shared types and constants for the laser frame transmitter.
// LASER_TX_PARITY_EN adds an even-parity bit per lane between data bit 7 and the stop bit.
package laser_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef LASER_TX_PARITY_EN
    StParity,
`endif
    StStop,
    StGap
  } laser_state_e;

  localparam logic LASER_IDLE_LEVEL  = 1'b0;
  localparam logic LASER_START_LEVEL = 1'b1;
  localparam logic LASER_STOP_LEVEL  = 1'b0;

  localparam int unsigned LASER_DATA_BITS          = 8;
  localparam int unsigned LASER_FRAME_BITS         = 10;
  localparam int unsigned LASER_FRAME_BITS_PARITY  = 11;

  function automatic logic even_parity(input logic [LASER_DATA_BITS-1:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/laser_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while run is high, held at 0 otherwise.
// bit_tick marks the last clock of each bit period.
module laser_bit_timer #(
  parameter int unsigned BIT_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic bit_tick
);

  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYCLES - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (cnt == LastCnt) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = run && (cnt == LastCnt);

endmodule

// File: rtl/laser_frame_tx.sv
// Dual-lane oversampled laser frame transmitter with a one-entry holding buffer.
// Optional LASER_TX_PARITY_EN inserts an even-parity bit per lane (11-bit frame).
module laser_frame_tx
  import laser_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 8,
  parameter int unsigned IDLE_GAP   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data1_in,
  input  logic [7:0] data2_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       laser1_out,
  output logic       laser2_out,
  output logic       laser_en,
  output logic       busy,
  output logic       done
);

  // Bit index is shared between data-bit counting and gap-period counting.
  localparam int unsigned GapW = $clog2(IDLE_GAP + 1);
  localparam int unsigned IdxW = (GapW > 3) ? GapW : 3;
  localparam logic [IdxW-1:0] LastData = IdxW'(LASER_DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastGap  = IdxW'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

  laser_state_e    state;
  logic            buf_full;
  logic [7:0]      buf1;
  logic [7:0]      buf2;
  logic [7:0]      shift1;
  logic [7:0]      shift2;
  logic [IdxW-1:0] bit_idx;
  logic            tick;
  logic            accept;
  logic            load;
  logic            line1;
  logic            line2;
`ifdef LASER_TX_PARITY_EN
  logic            par1;
  logic            par2;
`endif

  laser_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clock   (clock),
    .reset   (reset),
    .run     (state != StIdle),
    .bit_tick(tick)
  );

  assign data_ready = !buf_full;
  assign accept     = data_valid && data_ready;
  assign busy       = (state != StIdle);

  // Buffer moves into the shifters whenever the FSM is about to enter START.
  always_comb begin
    load = 1'b0;
    case (state)
      StIdle:  load = buf_full;
      StStop:  load = buf_full && tick && (IDLE_GAP == 0);
      StGap:   load = buf_full && tick && (bit_idx == LastGap);
      default: load = 1'b0;
    endcase
  end

  always_comb begin
    line1 = LASER_IDLE_LEVEL;
    line2 = LASER_IDLE_LEVEL;
    case (state)
      StStart: begin
        line1 = LASER_START_LEVEL;
        line2 = LASER_START_LEVEL;
      end
      StData: begin
        line1 = shift1[0];
        line2 = shift2[0];
      end
`ifdef LASER_TX_PARITY_EN
      StParity: begin
        line1 = par1;
        line2 = par2;
      end
`endif
      StStop: begin
        line1 = LASER_STOP_LEVEL;
        line2 = LASER_STOP_LEVEL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      buf_full   <= 1'b0;
      buf1       <= '0;
      buf2       <= '0;
      shift1     <= '0;
      shift2     <= '0;
      bit_idx    <= '0;
      laser1_out <= LASER_IDLE_LEVEL;
      laser2_out <= LASER_IDLE_LEVEL;
      laser_en   <= 1'b0;
      done       <= 1'b0;
`ifdef LASER_TX_PARITY_EN
      par1       <= 1'b0;
      par2       <= 1'b0;
`endif
    end else begin
      if (load) begin
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_full <= 1'b1;
        buf1     <= data1_in;
        buf2     <= data2_in;
      end

      if (load) begin
        shift1  <= buf1;
        shift2  <= buf2;
        bit_idx <= '0;
`ifdef LASER_TX_PARITY_EN
        par1    <= even_parity(buf1);
        par2    <= even_parity(buf2);
`endif
      end

      unique case (state)
        StIdle: begin
          if (load) state <= StStart;
        end
        StStart: begin
          if (tick) state <= StData;
        end
        StData: begin
          if (tick) begin
            shift1 <= shift1 >> 1;
            shift2 <= shift2 >> 1;
            if (bit_idx == LastData) begin
              bit_idx <= '0;
`ifdef LASER_TX_PARITY_EN
              state   <= StParity;
`else
              state   <= StStop;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef LASER_TX_PARITY_EN
        StParity: begin
          if (tick) state <= StStop;
        end
`endif
        StStop: begin
          if (tick) begin
            if (IDLE_GAP != 0) state <= StGap;
            else if (load)     state <= StStart;
            else               state <= StIdle;
          end
        end
        StGap: begin
          if (tick) begin
            if (bit_idx == LastGap) begin
              bit_idx <= '0;
              state   <= load ? StStart : StIdle;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase

      // Line outputs lag the state by one clock, so done lands on the last stop clock.
      laser1_out <= line1;
      laser2_out <= line2;
      laser_en   <= (state != StIdle) && (state != StGap);
      done       <= (state == StStop) && tick;
    end
  end

endmodule
